// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM encodings, round count and GF(2^8) / S-box helpers.
package aes_pkg;

    localparam int unsigned NR = 10;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_ADD   = 4'd1,
        S_ROUND = 4'd2,
        S_FINAL = 4'd3
    } state_e;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] acc;
        p   = a;
        acc = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // a^254 is the multiplicative inverse; maps 0 to 0 as AES requires
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int unsigned n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        return gf_inv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational inverse-cipher round; the final round skips InvMixColumns.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] iState,
    input  logic [127:0] iRoundKey,
    input  logic         iFinalRound,
    output logic [127:0] oState
);

    // InvShiftRows, InvSubBytes, AddRoundKey, then optional InvMixColumns
    always_comb begin
        logic [127:0] ark;
        logic [127:0] mix;
        logic [7:0]   a0, a1, a2, a3;
        ark = '0;
        mix = '0;
        // Byte 4c+r is row r of column c; row r rotates right by r columns
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                ark[127-8*(4*c+r) -: 8] = inv_sbox(iState[127-8*(4*((c-r+4)%4)+r) -: 8])
                                          ^ iRoundKey[127-8*(4*c+r) -: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            a0 = ark[127-32*c -: 8];
            a1 = ark[119-32*c -: 8];
            a2 = ark[111-32*c -: 8];
            a3 = ark[103-32*c -: 8];
            mix[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            mix[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            mix[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            mix[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        oState = iFinalRound ? ark : mix;
    end

endmodule

// File: rtl/aes_key_expansion.sv
// AES-128 key schedule: all 11 round keys, round key r at bits [128r+127:128r].
module aes_key_expansion
    import aes_pkg::*;
(
    input  logic [127:0]            iKey,
    output logic [128*(NR+1)-1:0]   oRoundKeys
);

    // Expand the whole schedule combinationally from the latched key
    always_comb begin
        logic [31:0] w [4*(NR+1)];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon       = 8'h01;
        t          = '0;
        oRoundKeys = '0;
        for (int i = 0; i < 4; i++) w[i] = iKey[127-32*i -: 32];
        for (int i = 4; i < 4 * (NR + 1); i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])}
                    ^ {rcon, 24'h000000};
                rcon = xtime(rcon);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= NR; r++) begin
            oRoundKeys[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
    end

endmodule

// File: rtl/aes_decrypt_core.sv
// Iterative AES-128 inverse cipher, one round per clock, 11 clocks start-to-done.
module aes_decrypt_core
    import aes_pkg::*;
#(
    parameter bit DONE_HOLD = 1'b0
) (
    input  logic         iClk,
    input  logic         iRst_n,
    input  logic         iStart,
    input  logic [127:0] iCiphertext,
    input  logic [127:0] iKey,
    output logic [127:0] oPlaintext,
    output logic         oBusy,
    output logic         oDone
);

    state_e       state_q, state_d;
    logic [3:0]   round_q, round_d;
    logic [127:0] ct_q, ct_d;
    logic [127:0] key_q, key_d;
    logic [127:0] st_q, st_d;
    logic [127:0] pt_q, pt_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    logic [128*(NR+1)-1:0] round_keys;
    logic [127:0]          rk_arr [NR+1];
    logic [3:0]            rk_idx;
    logic [127:0]          rk;
    logic [127:0]          round_out;

    // Schedule comes from the latched key so input changes mid-run are harmless
    aes_key_expansion u_key_exp (
        .iKey       (key_q),
        .oRoundKeys (round_keys)
    );

    // Select w[10] for the initial AddRoundKey, otherwise w[round]
    always_comb begin
        for (int r = 0; r <= NR; r++) rk_arr[r] = round_keys[128*r +: 128];
        rk_idx = (state_q == S_ADD) ? 4'(NR) : round_q;
        rk     = rk_arr[rk_idx];
    end

    aes_inv_round u_inv_round (
        .iState      (st_q),
        .iRoundKey   (rk),
        .iFinalRound (round_q == 4'd0),
        .oState      (round_out)
    );

    // FSM next-state and datapath updates
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        ct_d    = ct_q;
        key_d   = key_q;
        st_d    = st_q;
        pt_d    = pt_q;
        busy_d  = busy_q;
        done_d  = DONE_HOLD ? done_q : 1'b0;
        case (state_q)
            S_IDLE: begin
                if (iStart) begin
                    ct_d    = iCiphertext;
                    key_d   = iKey;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                st_d    = ct_q ^ rk;
                round_d = 4'd9;
                state_d = S_ROUND;
            end
            S_ROUND: begin
                st_d    = round_out;
                round_d = round_q - 4'd1;
                if (round_q == 4'd1) state_d = S_FINAL;
            end
            S_FINAL: begin
                pt_d    = round_out;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                round_d = 4'd0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state_q <= S_IDLE;
            round_q <= 4'd0;
            ct_q    <= '0;
            key_q   <= '0;
            st_q    <= '0;
            pt_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            ct_q    <= ct_d;
            key_q   <= key_d;
            st_q    <= st_d;
            pt_q    <= pt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign oPlaintext = pt_q;
    assign oBusy      = busy_q;
    assign oDone      = done_q;

endmodule

// File: tb/tb_aes_decrypt_core.sv
// Directed bench for aes_decrypt_core; a second instance covers DONE_HOLD=1.
module tb_aes_decrypt_core;

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;

    logic         iClk = 1'b0;
    logic         iRst_n;
    logic         iStart;
    logic [127:0] iCiphertext;
    logic [127:0] iKey;
    logic [127:0] pt, pt_h;
    logic         busy, busy_h, done, done_h;

    int n_checks = 0;
    int n_errors = 0;

    always #5 iClk = ~iClk;

    aes_decrypt_core #(.DONE_HOLD(1'b0)) dut (
        .iClk        (iClk),
        .iRst_n      (iRst_n),
        .iStart      (iStart),
        .iCiphertext (iCiphertext),
        .iKey        (iKey),
        .oPlaintext  (pt),
        .oBusy       (busy),
        .oDone       (done)
    );

    aes_decrypt_core #(.DONE_HOLD(1'b1)) dut_h (
        .iClk        (iClk),
        .iRst_n      (iRst_n),
        .iStart      (iStart),
        .iCiphertext (iCiphertext),
        .iKey        (iKey),
        .oPlaintext  (pt_h),
        .oBusy       (busy_h),
        .oDone       (done_h)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just past the rising edge
    task automatic cyc();
        @(posedge iClk);
        #1;
    endtask

    task automatic start_op(input logic [127:0] ct, input logic [127:0] k);
        iCiphertext = ct;
        iKey        = k;
        iStart      = 1'b1;
        cyc();
        iStart      = 1'b0;
    endtask

    // k0 = index of the edge just passed, counted from the accepting edge E0
    task automatic wait_done(input int k0, output int lat, output int bcnt);
        lat  = -1;
        bcnt = busy ? 1 : 0;
        for (int k = k0 + 1; k <= k0 + 30 && lat < 0; k++) begin
            cyc();
            if (busy) bcnt++;
            if (done) lat = k;
        end
    endtask

    task automatic count_dones(input int n, output int cnt);
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            cyc();
            if (done || busy) cnt++;
        end
    endtask

    initial begin
        int lat, bcnt, cnt;
        iRst_n      = 1'b0;
        iStart      = 1'b0;
        iCiphertext = '0;
        iKey        = '0;
        cyc();
        cyc();
        check_eq("rst_busy", 128'(busy), 128'd0);
        check_eq("rst_done", 128'(done), 128'd0);
        check_eq("rst_pt", pt, 128'd0);
        iRst_n = 1'b1;
        cyc();

        // FIPS-197 C.1 with latency and busy-window checks
        start_op(C1, K1);
        wait_done(0, lat, bcnt);
        check_eq("c1_lat", 128'(lat), 128'd11);
        check_eq("c1_busy_cycles", 128'(bcnt), 128'd11);
        check_eq("c1_pt", pt, P1);
        check_eq("c1_hold_done", 128'(done_h), 128'd1);
        cyc();
        check_eq("c1_done_drop", 128'(done), 128'd0);
        check_eq("c1_hold_keep", 128'(done_h), 128'd1);
        check_eq("c1_busy_idle", 128'(busy), 128'd0);

        // FIPS-197 App.B; hold build drops oDone on acceptance
        start_op(C2, K2);
        check_eq("b_hold_clear", 128'(done_h), 128'd0);
        wait_done(0, lat, bcnt);
        check_eq("b_lat", 128'(lat), 128'd11);
        check_eq("b_pt", pt, P2);

        // Inputs scrambled and start re-pulsed at E3 while busy
        start_op(C1, K1);
        cyc();
        cyc();
        iCiphertext = {$urandom, $urandom, $urandom, $urandom};
        iKey        = {$urandom, $urandom, $urandom, $urandom};
        iStart      = 1'b1;
        cyc();
        iStart = 1'b0;
        wait_done(3, lat, bcnt);
        check_eq("ign_lat", 128'(lat), 128'd11);
        check_eq("ign_pt", pt, P1);
        count_dones(20, cnt);
        check_eq("ign_no_second", 128'(cnt), 128'd0);

        // Reset at E5 aborts the run
        start_op(C1, K1);
        for (int k = 0; k < 4; k++) cyc();
        iRst_n = 1'b0;
        cyc();
        check_eq("abort_busy", 128'(busy), 128'd0);
        check_eq("abort_pt", pt, 128'd0);
        check_eq("abort_done", 128'(done), 128'd0);
        iRst_n = 1'b1;
        count_dones(15, cnt);
        check_eq("abort_no_done", 128'(cnt), 128'd0);
        start_op(C2, K2);
        wait_done(0, lat, bcnt);
        check_eq("abort_rerun_pt", pt, P2);

        // iStart held high: back-to-back runs every 12 clocks
        iCiphertext = C1;
        iKey        = K1;
        iStart      = 1'b1;
        cyc();
        iCiphertext = C2;
        iKey        = K2;
        wait_done(0, lat, bcnt);
        check_eq("b2b_lat1", 128'(lat), 128'd11);
        check_eq("b2b_pt1", pt, P1);
        check_eq("b2b_hold_e11", 128'(done_h), 128'd1);
        cyc();
        check_eq("b2b_done_e12", 128'(done), 128'd0);
        check_eq("b2b_hold_e12", 128'(done_h), 128'd0);
        check_eq("b2b_busy_e12", 128'(busy), 128'd1);
        iCiphertext = C1;
        iKey        = K1;
        wait_done(12, lat, bcnt);
        iStart = 1'b0;
        check_eq("b2b_lat2", 128'(lat), 128'd23);
        check_eq("b2b_pt2", pt, P2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
